// File: rtl/hpdmc_wrpath16_pkg.sv
// Shared definitions for the 16-bit DDR write-data path.
//   wr_state_t : write scheduler states (IDLE=0, WAIT=1, BURST=2, POST=3)
//   MASK_IDLE  : data-mask value that blocks both bytes of a beat
//   wr_word_t  : one buffered write word, byte masks on top of the data
package hpdmc_wrpath16_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BURST = 2'd2,
    ST_POST  = 2'd3
  } wr_state_t;

  localparam logic [1:0] MASK_IDLE = 2'b11;
  localparam int         WORD_W    = 36;

  typedef struct packed {
    logic [3:0]  mask;
    logic [31:0] data;
  } wr_word_t;

endpackage

// File: rtl/hpdmc_wrpath16_if.sv
// Bus between the controller's bus/command logic and the write-data path.
//   master : controller side (offers write words, issues wr_start)
//   slave  : write-data path (accepts words, drives the DDR output registers)
// Signals:
//   din/din_mask/din_valid/din_ready : write word handshake
//   wr_start/wr_busy                 : write command pulse and burst-in-progress
//   d0/d1/dm0/dm1/oce                : DDR data/mask register inputs and clock enable
//   dq_oe/dqs_oe                     : DQ/DM and DQS tristate enables (1 = drive)
//   underrun                         : a burst beat found the buffer empty
//   level                            : current buffer occupancy (status)
interface hpdmc_wrpath16_if;
  logic [31:0] din;
  logic [3:0]  din_mask;
  logic        din_valid;
  logic        din_ready;
  logic        wr_start;
  logic        wr_busy;
  logic [15:0] d0;
  logic [15:0] d1;
  logic [1:0]  dm0;
  logic [1:0]  dm1;
  logic        oce;
  logic        dq_oe;
  logic        dqs_oe;
  logic        underrun;
  logic [7:0]  level;

  modport master (
    output din, din_mask, din_valid, wr_start,
    input  din_ready, wr_busy, d0, d1, dm0, dm1, oce, dq_oe, dqs_oe, underrun, level
  );

  modport slave (
    input  din, din_mask, din_valid, wr_start,
    output din_ready, wr_busy, d0, d1, dm0, dm1, oce, dq_oe, dqs_oe, underrun, level
  );
endinterface

// File: rtl/hpdmc_wrpath16_wrfifo.sv
// Write word buffer: WIDTH bits wide, DEPTH (power of two) entries deep.
// Pointers and occupancy are registered; read data is the entry at the read
// pointer and is valid whenever empty is low.
//   clk, rst     : clock, asynchronous active-high reset (flushes the buffer)
//   push, wdata  : write an entry (ignored when full)
//   pop, rdata   : consume the head entry (ignored when empty)
//   full, empty  : occupancy flags
//   level        : number of stored entries
module hpdmc_wrfifo #(
  parameter  int WIDTH = 36,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign level   = cnt;
  assign rdata   = mem[rptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/hpdmc_wrpath16.sv
// Write-data scheduler for the 16-bit DDR SDRAM Spartan-3 I/O. Buffers 32-bit
// write words with byte masks and, on each wr_start, replays one burst of
// BURST_WORDS words aligned to the write latency WL, with a one-cycle DQS
// preamble before the data and a one-cycle postamble after it.
//   sys_clk   : system clock (also clocks the DDR output registers)
//   sdram_rst : asynchronous active-high reset
//   bus       : hpdmc_wrpath16_if.slave (word handshake, command, DDR outputs)
module hpdmc_wrpath16
  import hpdmc_wrpath16_pkg::*;
#(
  parameter int BURST_WORDS = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int WL          = 1
) (
  input  logic               sys_clk,
  input  logic               sdram_rst,
  hpdmc_wrpath16_if.slave    bus
);

  localparam int AW = $clog2(FIFO_DEPTH);

  wr_state_t   state;
  wr_state_t   state_n;
  logic [2:0]  cnt;
  logic [2:0]  cnt_n;

  wr_word_t    fifo_wdata;
  wr_word_t    fifo_rdata;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_push;
  logic        fifo_pop;
  logic [AW:0] fifo_level;

  logic        beat_n;
  logic        dqs_n;

  logic [15:0] d0_p1;
  logic [15:0] d1_p1;
  logic [1:0]  dm0_p1;
  logic [1:0]  dm1_p1;
  logic        oce_p1;
  logic        dq_oe_p1;
  logic        dqs_oe_p1;
  logic        underrun_p1;

  // Not ready during reset so no word is lost while the buffer is held flushed.
  assign bus.din_ready = ~fifo_full & ~sdram_rst;
  assign fifo_wdata    = '{mask: bus.din_mask, data: bus.din};
  assign fifo_push     = bus.din_valid & bus.din_ready;

  hpdmc_wrfifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (sys_clk),
    .rst   (sdram_rst),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_ff @(posedge sys_clk or posedge sdram_rst) begin
    if (sdram_rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // One counter serves as latency counter in WAIT and beat counter in BURST.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      ST_IDLE: begin
        if (bus.wr_start) begin
          state_n = ST_WAIT;
          cnt_n   = 3'(WL - 1);
        end
      end
      ST_WAIT: begin
        if (cnt == 3'd0) begin
          state_n = ST_BURST;
          cnt_n   = 3'(BURST_WORDS - 1);
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      ST_BURST: begin
        if (cnt == 3'd0) state_n = ST_POST;
        else             cnt_n   = cnt - 1'b1;
      end
      ST_POST:  state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state
  // the FSM occupies; the word for a beat is popped one cycle ahead of it.
  assign beat_n   = (state_n == ST_BURST);
  assign dqs_n    = beat_n | (state_n == ST_POST) | ((state_n == ST_WAIT) && (cnt_n == 3'd0));
  assign fifo_pop = beat_n & ~fifo_empty;

  // Stage p1: DDR register inputs. An empty buffer still yields a full-length,
  // fully masked data phase.
  always_ff @(posedge sys_clk or posedge sdram_rst) begin
    if (sdram_rst) begin
      d0_p1       <= '0;
      d1_p1       <= '0;
      dm0_p1      <= MASK_IDLE;
      dm1_p1      <= MASK_IDLE;
      oce_p1      <= 1'b0;
      dq_oe_p1    <= 1'b0;
      dqs_oe_p1   <= 1'b0;
      underrun_p1 <= 1'b0;
    end else begin
      oce_p1      <= beat_n;
      dq_oe_p1    <= beat_n;
      dqs_oe_p1   <= dqs_n;
      underrun_p1 <= beat_n & fifo_empty;
      if (fifo_pop) begin
        d0_p1  <= fifo_rdata.data[31:16];
        d1_p1  <= fifo_rdata.data[15:0];
        dm0_p1 <= fifo_rdata.mask[3:2];
        dm1_p1 <= fifo_rdata.mask[1:0];
      end else begin
        d0_p1  <= '0;
        d1_p1  <= '0;
        dm0_p1 <= MASK_IDLE;
        dm1_p1 <= MASK_IDLE;
      end
    end
  end

  assign bus.d0       = d0_p1;
  assign bus.d1       = d1_p1;
  assign bus.dm0      = dm0_p1;
  assign bus.dm1      = dm1_p1;
  assign bus.oce      = oce_p1;
  assign bus.dq_oe    = dq_oe_p1;
  assign bus.dqs_oe   = dqs_oe_p1;
  assign bus.underrun = underrun_p1;
  assign bus.wr_busy  = (state != ST_IDLE);
  assign bus.level    = 8'(fifo_level);

endmodule
